// File: rtl/trng_harvester.sv
// rtl/trng_harvester.sv - health-checked TRNG word harvester
// Collects W fresh bits, runs RCT and ones-proportion checks, presents words over valid/ready.
module trng_harvester #(
  parameter int W          = 128,
  parameter int RCT_CUTOFF = 32,
  parameter int PROP_LO    = 40,
  parameter int PROP_HI    = 88
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] rnd_word,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         health_fail,
  input  logic         clr_fail,
  output logic [7:0]   disc_cnt
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int PW = CW + 1;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, FAIL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] fill_cnt, fill_cnt_nxt;
  logic [RW-1:0] run_len, run_len_nxt, run_obs;
  logic          last_bit, last_bit_nxt;
  logic [W-1:0]  out_data_nxt;
  logic          out_valid_nxt;
  logic          health_fail_nxt;
  logic [7:0]    disc_cnt_nxt;
  logic [PW-1:0] ones;
  logic          bit_in, trip, in_range, win_done;

  assign bit_in = rnd_word[0];

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + PW'(rnd_word[i]);
    end
  end

  // Run length as it would be after observing bit_in; saturates at the cutoff.
  always_comb begin
    if (run_len == '0 || bit_in != last_bit) begin
      run_obs = RW'(1);
    end else if (run_len == RW'(RCT_CUTOFF)) begin
      run_obs = run_len;
    end else begin
      run_obs = run_len + RW'(1);
    end
  end

  assign trip     = (run_obs == RW'(RCT_CUTOFF));
  assign in_range = (ones >= PW'(PROP_LO)) && (ones <= PW'(PROP_HI));
  assign win_done = (fill_cnt == CW'(W - 1));

  always_comb begin
    state_nxt       = state;
    fill_cnt_nxt    = fill_cnt;
    run_len_nxt     = run_len;
    last_bit_nxt    = last_bit;
    out_data_nxt    = out_data;
    out_valid_nxt   = out_valid;
    health_fail_nxt = health_fail;
    disc_cnt_nxt    = disc_cnt;
    case (state)
      IDLE: begin
        run_len_nxt = '0;
        if (en) begin
          state_nxt    = FILL;
          fill_cnt_nxt = '0;
        end
      end
      FILL: begin
        if (!en) begin
          state_nxt    = IDLE;
          fill_cnt_nxt = '0;
          run_len_nxt  = '0;
        end else begin
          run_len_nxt  = run_obs;
          last_bit_nxt = bit_in;
          if (trip) begin
            health_fail_nxt = 1'b1;
            out_valid_nxt   = 1'b0;
            fill_cnt_nxt    = '0;
            state_nxt       = FAIL;
          end else if (win_done) begin
            fill_cnt_nxt = '0;
            if (in_range) begin
              out_data_nxt  = rnd_word;
              out_valid_nxt = 1'b1;
              state_nxt     = HOLD;
            end else if (disc_cnt != 8'hFF) begin
              disc_cnt_nxt = disc_cnt + 8'd1;
            end
          end else begin
            fill_cnt_nxt = fill_cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        // The RCT stays live while waiting; a trip overrides any concurrent transfer.
        run_len_nxt  = run_obs;
        last_bit_nxt = bit_in;
        if (trip) begin
          health_fail_nxt = 1'b1;
          out_valid_nxt   = 1'b0;
          fill_cnt_nxt    = '0;
          state_nxt       = FAIL;
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
          fill_cnt_nxt  = '0;
          if (en) begin
            state_nxt = FILL;
          end else begin
            state_nxt   = IDLE;
            run_len_nxt = '0;
          end
        end
      end
      FAIL: begin
        out_valid_nxt = 1'b0;
        if (clr_fail) begin
          health_fail_nxt = 1'b0;
          run_len_nxt     = '0;
          fill_cnt_nxt    = '0;
          state_nxt       = en ? FILL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      run_len     <= '0;
      last_bit    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      health_fail <= 1'b0;
      disc_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      fill_cnt    <= fill_cnt_nxt;
      run_len     <= run_len_nxt;
      last_bit    <= last_bit_nxt;
      out_data    <= out_data_nxt;
      out_valid   <= out_valid_nxt;
      health_fail <= health_fail_nxt;
      disc_cnt    <= disc_cnt_nxt;
    end
  end

endmodule

// File: doc/trng_harvester.md
Name: trng_harvester

Overview:
- Downstream consumer of the ring-oscillator TRNG shift-register output.
- Collects a full window of fresh bits, health-checks them and presents one 128-bit random word at a time over a valid/ready handshake to the LPN PUF datapath.
- Health checks are a continuous repetition-count test (RCT) on the newest bit and a per-word ones-proportion check. An RCT failure latches and blocks output until software clears it.

Parameters:
- W, 128: word width. Must equal the TRNG shift-register width.
- RCT_CUTOFF, 32: run length of identical consecutive bits that trips the RCT.
- PROP_LO, 40: minimum ones count for an accepted word (inclusive).
- PROP_HI, 88: maximum ones count for an accepted word (inclusive).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  harvesting enable
- rnd_word  in  W  TRNG shift register; bit 0 is the bit shifted in at the previous edge
- out_data  out  W  harvested word
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data
- health_fail  out  1  sticky RCT failure flag
- clr_fail  in  1  one-cycle pulse; clears health_fail
- disc_cnt  out  8  saturating count of words discarded by the proportion check

Behaviour:
- Reset values (asynchronous):
  - out_data=0, out_valid=0, health_fail=0, disc_cnt=0.
  - State=IDLE, fill_cnt=0, run_len=0, last_bit=0.
- States: IDLE, FILL, HOLD, FAIL.
- Each clock in FILL or HOLD observes one new bit, b = rnd_word[0].
- IDLE:
  - en=1 -> FILL with fill_cnt=0.
  - run_len is 0 in IDLE.
- FILL:
  - Each cycle: fill_cnt++.
  - RCT update: if run_len=0 or b!=last_bit then run_len=1, else run_len++. last_bit=b.
  - On the edge where fill_cnt==W-1, rnd_word holds exactly the W bits observed in FILL. Popcount it:
    - Popcount in [PROP_LO, PROP_HI] -> out_data<=rnd_word, out_valid<=1, go to HOLD.
    - Otherwise -> discard: disc_cnt++ (saturates at 255), fill_cnt=0, stay in FILL.
  - en=0 -> IDLE next cycle; fill_cnt and run_len cleared; partial window lost.
- Latency: the first out_valid rises W cycles after FILL entry. Cycles 0..W-1 observe bits; out_valid is high in cycle W.
- HOLD:
  - out_data is stable while out_valid=1 and out_ready=0.
  - The RCT keeps updating every cycle.
  - out_valid & out_ready -> out_valid<=0. Next state is FILL (fill_cnt=0) if en=1, else IDLE.
  - en=0 while holding does not drop out_valid; the pending word must transfer first.
  - No fresh bits are counted during HOLD. The next word always uses W bits observed after the transfer.
- RCT trip:
  - When the updated run_len reaches RCT_CUTOFF in FILL or HOLD: health_fail<=1, out_valid<=0, go to FAIL.
  - If the trip cycle also has out_valid & out_ready, that transfer is complete and valid. The trip still wins the state transition.
- FAIL:
  - No observation; out_valid=0; en is ignored.
  - clr_fail=1 -> health_fail<=0, run_len=0, fill_cnt=0, next state FILL if en=1, else IDLE.
- clr_fail outside FAIL: no effect.
- Widths:
  - fill_cnt is clog2(W) bits.
  - run_len saturates at RCT_CUTOFF.
  - Popcount is clog2(W)+1 bits, compared unsigned.
- Reset asserted mid-operation returns everything to reset values immediately; no word is emitted.

Test Plan:
- Reset, en=1, rnd_word driven by an alternating 0/1 source, out_ready=1 -> out_valid high exactly 128 cycles after FILL entry; out_data=0xAAAA...A or 0x5555...5 per phase; disc_cnt=0.
- Source with a 3-bit pattern 110 (no run longer than 2), out_ready held 0 for 50 cycles -> out_data and out_valid stable for 50 cycles; after the ready pulse, the next word appears 128 cycles later.
- Source with ones density of 1/8 (16 ones per word) -> every window discarded; disc_cnt increments every 128 cycles and saturates at 255; out_valid never asserts.
- Source stuck at 1 -> health_fail=1 at the 32nd observed bit; out_valid=0; then pulse clr_fail with the source switched to alternating -> health_fail=0 and a valid word 128 cycles later.
- Drop en at fill_cnt=60 and reassert -> no word is emitted from the partial window; the next word needs a full 128 observations.
- Assert reset while in HOLD with out_valid=1 -> out_valid=0, out_data=0 and disc_cnt=0 immediately, without waiting for a clock edge.
